// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port synchronous pixel RAM between three requesters in
//   the pixel-clock domain, fixed priority display > clear > host:
//     - scan-out reader: always granted, read data back 3 cycles after request
//     - clear engine:    fills 0..DEPTH-1 with one colour on display gaps
//     - host/draw port:  valid/ready commands, reads answered in 3 cycles
//
//   Ports
//     clk, reset                     pixel clock, async active-high reset
//     disp_req/disp_addr             scan-out read request
//     disp_valid/disp_data           scan-out pixel (registered)
//     host_valid/ready/we/addr/wdata host command handshake
//     host_rsp_valid/host_rsp_data   host read data (no back-pressure)
//     clear_start/clear_color        start a full-framebuffer fill
//     clear_busy/clear_done          fill in progress / one-cycle completion
//     mem_en/we/addr/wdata/rdata     RAM port (outputs registered)
//     stall_count                    only when FB_ARB_STATS_EN is defined:
//                                    saturating count of host stall cycles
//
//   Build option: define FB_ARB_STATS_EN to add the stall_count port/counter.
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int AW    = 19,
   parameter int DW    = 8,
   parameter int DEPTH = 480000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_valid,
   output logic [DW-1:0] disp_data,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_rsp_valid,
   output logic [DW-1:0] host_rsp_data,
   input  logic          clear_start,
   input  logic [DW-1:0] clear_color,
   output logic          clear_busy,
   output logic          clear_done,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
   ,
   output logic [15:0]   stall_count
`endif
);

   // Clear engine states. FLUSH covers the cycle in which the last fill
   // write sits on the RAM bus, so clear_done lands two cycles after the
   // final write was granted.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Owner tag carried alongside each RAM access.
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_DISP = 2'd1;
   localparam logic [1:0] TAG_HOST = 2'd2;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] color_q, color_d;

   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;

   logic [1:0]    tag_mem_q, tag_mem_d;   // aligned with the RAM command
   logic [1:0]    tag_rd_q, tag_rd_d;     // aligned with mem_rdata

   logic          disp_valid_q, disp_valid_d;
   logic [DW-1:0] disp_data_q, disp_data_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;

   logic          gnt_disp, gnt_clr, gnt_host;

   assign clear_busy = (state_q != S_IDLE);
   assign clear_done = (state_q == S_DONE);
   // Gated by reset so every output reads 0 while reset is held.
   assign host_ready = host_valid & ~disp_req & ~clear_busy & ~reset;

   // Fixed-priority grant.
   always_comb begin
      gnt_disp = disp_req;
      gnt_clr  = ~disp_req & (state_q == S_CLEAR);
      gnt_host = host_ready;
   end

   // Clear engine.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      color_d = color_q;
      case (state_q)
         S_IDLE: begin
            if (clear_start) begin
               color_d = clear_color;
               cnt_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (gnt_clr) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) state_d = S_FLUSH;
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // RAM command stage and read-return pipeline.
   always_comb begin
      mem_en_d    = gnt_disp | gnt_clr | gnt_host;
      mem_we_d    = ~gnt_disp & (gnt_clr | (gnt_host & host_we));
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      tag_mem_d   = TAG_NONE;
      if (gnt_disp) begin
         mem_addr_d = disp_addr;
         tag_mem_d  = TAG_DISP;
      end else if (gnt_clr) begin
         mem_addr_d  = cnt_q;
         mem_wdata_d = color_q;
      end else if (gnt_host) begin
         mem_addr_d = host_addr;
         if (host_we) mem_wdata_d = host_wdata;
         else         tag_mem_d   = TAG_HOST;
      end

      tag_rd_d     = tag_mem_q;
      disp_valid_d = (tag_rd_q == TAG_DISP);
      disp_data_d  = disp_valid_d ? mem_rdata : '0;
      rsp_valid_d  = (tag_rd_q == TAG_HOST);
      rsp_data_d   = rsp_valid_d ? mem_rdata : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         color_q      <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tag_mem_q    <= TAG_NONE;
         tag_rd_q     <= TAG_NONE;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         color_q      <= color_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         tag_mem_q    <= tag_mem_d;
         tag_rd_q     <= tag_rd_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign mem_en         = mem_en_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign disp_valid     = disp_valid_q;
   assign disp_data      = disp_data_q;
   assign host_rsp_valid = rsp_valid_q;
   assign host_rsp_data  = rsp_data_q;

`ifdef FB_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (host_valid && !host_ready && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_count = stall_q;
`endif

endmodule
